id_stage: RTL and testbench
===========================

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameter IW, 12, instruction width in bits.
REQ-002 Parameter IMW, 4, instruction address (PC) width in bits.
REQ-003 Parameter RFW, 2, register address width; register file holds 2**RFW registers.
REQ-004 Constraint: IW SHALL be >= 2+3*RFW; field layout op=[1:0], rd=[2+RFW-1:2], rs1=next RFW bits, rs2=next RFW bits.
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 in_valid  in  1  fetch presents an instruction.
REQ-008 in_ready  out  1  stage accepts the instruction this cycle.
REQ-009 in_instr  in  IW  instruction word; in_pc  in  IMW  its address.
REQ-010 out_valid  out  1  decoded entry held; out_ready  in  1  downstream accepts.
REQ-011 out_instr  out  IW; out_pc  out  IMW; registered copies of the accepted entry.
REQ-012 out_rs1, out_rs2, out_rd  out  RFW each  decoded register addresses.
REQ-013 out_rf_we  out  1; out_branch  out  1  decoded controls.
REQ-014 wb_valid  in  1; wb_rd  in  RFW  writeback retires a pending write to wb_rd.
REQ-015 br_done  in  1  branch resolved pulse; flush  in  1  discard held entry.
REQ-016 sb_busy  out  1  any scoreboard bit set.

Function
REQ-017 Decode: rf_we = (op==`OP_R or `OP_I) and rd != `REG0; branch = (op==`OP_B); out_rd SHALL be 0 when rf_we is 0 (no X).
REQ-018 One output register; accept (in_valid & in_ready) loads it next edge; latency in->out 1 cycle.
REQ-019 in_ready = state RUN & !flush & !hazard & (!out_valid | out_ready).
REQ-020 Scoreboard: one pending bit per register; bit for out_rd SET when out_valid & out_ready & out_rf_we.
REQ-021 Bit CLEARED on wb_valid for wb_rd; same-cycle set and clear of one register -> set wins.
REQ-022 Hazard: in_instr rs1 or rs2 (non-zero) matches a pending bit, or matches out_rd while out_valid & out_rf_we.
REQ-023 Reads of register 0 SHALL never raise hazard; bit 0 SHALL never be set.
REQ-024 FSM: RUN -> BR_WAIT on accepting an instruction with branch=1; BR_WAIT -> RUN on br_done; in_ready=0 in BR_WAIT.
REQ-025 br_done in RUN SHALL be ignored.
REQ-026 flush: next edge out_valid=0, FSM -> RUN; scoreboard SHALL keep all bits; flush overrides a same-cycle accept.
REQ-027 out_valid & !out_ready SHALL hold all out_* stable.
REQ-028 sb_busy = OR of pending bits, combinational.

Reset
REQ-029 On rst: out_valid=0, out_instr/out_pc/out_rs1/out_rs2/out_rd=0, out_rf_we=0, out_branch=0, all pending bits 0, FSM=RUN.
REQ-030 rst mid-operation SHALL discard the held entry and all pending writes immediately (asynchronous).

Configuration
REQ-031 Macro ID_WB_BYPASS_EN defined: pending bit cleared by wb_valid this cycle SHALL NOT cause hazard (combinational bypass, issue same cycle).
REQ-032 Macro ID_WB_BYPASS_EN undefined: hazard uses registered bits only; dependent instruction issues one cycle after wb.

Verification
REQ-033 Reset, then R rd=1 rs1=2 rs2=3, out_ready=1 -> out_valid next cycle, out_rd=1, out_rf_we=1, bit1 set after handoff, sb_busy=1.
REQ-034 Then R rs1=1 -> in_ready=0 until wb_valid wb_rd=1; accept same cycle with ID_WB_BYPASS_EN, one cycle later without.
REQ-035 I-type rd=0 -> out_rf_we=0, out_rd=0, no bit set; following read of r0 accepted without stall.
REQ-036 B-type accepted -> in_ready=0 for 3 cycles; br_done pulse -> in_ready=1 next cycle.
REQ-037 Entry held with out_ready=0 for 4 cycles -> out_* stable; flush -> out_valid=0 next cycle, no bit set for its rd.
REQ-038 wb_valid wb_rd=2 coincident with handoff of rd=2 writer -> bit2 remains set.

Source files
------------

// File: rtl/id_stage.sv
// id_stage: single-entry decode register with a per-register pending-write scoreboard and branch stall.
// Optional feature: define ID_WB_BYPASS_EN to let a same-cycle writeback release a hazard.
`ifndef OP_R
`define OP_R 2'b00
`endif
`ifndef OP_I
`define OP_I 2'b01
`endif
`ifndef OP_B
`define OP_B 2'b10
`endif
`ifndef REG0
`define REG0 {RFW{1'b0}}
`endif

module id_stage #(
  parameter int IW  = 12,
  parameter int IMW = 4,
  parameter int RFW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [IW-1:0]  in_instr,
  input  logic [IMW-1:0] in_pc,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [IW-1:0]  out_instr,
  output logic [IMW-1:0] out_pc,
  output logic [RFW-1:0] out_rs1,
  output logic [RFW-1:0] out_rs2,
  output logic [RFW-1:0] out_rd,
  output logic           out_rf_we,
  output logic           out_branch,
  input  logic           wb_valid,
  input  logic [RFW-1:0] wb_rd,
  input  logic           br_done,
  input  logic           flush,
  output logic           sb_busy
);

  localparam int NREG = 2 ** RFW;

  typedef enum logic {ST_RUN = 1'b0, ST_BR_WAIT = 1'b1} state_t;

  state_t          state_r, state_next_s;
  logic [NREG-1:0] pend_r, pend_next_s, pend_haz_s, wb_clr_s, hs_set_s;
  logic [1:0]      dec_op_s;
  logic [RFW-1:0]  dec_rd_s, dec_rs1_s, dec_rs2_s;
  logic            dec_we_s, dec_br_s;
  logic            hazard_s, accept_s, handoff_s;

  // A source register is busy if a write to it is pending or is sitting in the output register.
  function automatic logic reg_busy(input logic [RFW-1:0] rs, input logic [NREG-1:0] pend,
                                    input logic held_we, input logic [RFW-1:0] held_rd);
    logic busy;
    if (rs == `REG0) begin
      busy = 1'b0;
    end else begin
      busy = pend[rs] | (held_we & (held_rd == rs));
    end
    return busy;
  endfunction

  // Field extraction and control decode of the incoming word.
  always_comb begin
    dec_op_s  = in_instr[1:0];
    dec_rs1_s = in_instr[2+2*RFW-1 -: RFW];
    dec_rs2_s = in_instr[2+3*RFW-1 -: RFW];
    dec_br_s  = (dec_op_s == `OP_B);
    dec_we_s  = ((dec_op_s == `OP_R) || (dec_op_s == `OP_I)) && (in_instr[2+RFW-1:2] != `REG0);
    if (dec_we_s) begin
      dec_rd_s = in_instr[2+RFW-1:2];
    end else begin
      dec_rd_s = `REG0;
    end
  end

  // Scoreboard set/clear vectors; a handoff set wins over a writeback clear of the same register.
  always_comb begin
    wb_clr_s = {NREG{1'b0}};
    hs_set_s = {NREG{1'b0}};
    if (wb_valid) begin
      wb_clr_s[wb_rd] = 1'b1;
    end else begin
      wb_clr_s = {NREG{1'b0}};
    end
    if (handoff_s && out_rf_we) begin
      hs_set_s[out_rd] = 1'b1;
    end else begin
      hs_set_s = {NREG{1'b0}};
    end
    pend_next_s    = (pend_r & ~wb_clr_s) | hs_set_s;
    pend_next_s[0] = 1'b0;
`ifdef ID_WB_BYPASS_EN
    pend_haz_s = pend_r & ~wb_clr_s;
`else
    pend_haz_s = pend_r;
`endif
  end

  assign handoff_s = out_valid & out_ready;
  assign hazard_s  = reg_busy(dec_rs1_s, pend_haz_s, out_valid & out_rf_we, out_rd) |
                     reg_busy(dec_rs2_s, pend_haz_s, out_valid & out_rf_we, out_rd);
  assign in_ready  = (state_r == ST_RUN) & ~flush & ~hazard_s & (~out_valid | out_ready);
  assign accept_s  = in_valid & in_ready;
  assign sb_busy   = |pend_r;

  // Branch-wait FSM next state; flush always returns to RUN.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (accept_s && dec_br_s) begin
          state_next_s = ST_BR_WAIT;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_BR_WAIT: begin
        if (br_done) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_BR_WAIT;
        end
      end
      default: state_next_s = ST_RUN;
    endcase
    if (flush) begin
      state_next_s = ST_RUN;
    end else begin
      state_next_s = state_next_s;
    end
  end

  // FSM and scoreboard registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_RUN;
      pend_r  <= {NREG{1'b0}};
    end else begin
      state_r <= state_next_s;
      pend_r  <= pend_next_s;
    end
  end

  // Output register: flush discards, accept loads, handoff empties, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_instr  <= {IW{1'b0}};
      out_pc     <= {IMW{1'b0}};
      out_rs1    <= {RFW{1'b0}};
      out_rs2    <= {RFW{1'b0}};
      out_rd     <= {RFW{1'b0}};
      out_rf_we  <= 1'b0;
      out_branch <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept_s) begin
      out_valid  <= 1'b1;
      out_instr  <= in_instr;
      out_pc     <= in_pc;
      out_rs1    <= dec_rs1_s;
      out_rs2    <= dec_rs2_s;
      out_rd     <= dec_rd_s;
      out_rf_we  <= dec_we_s;
      out_branch <= dec_br_s;
    end else if (handoff_s) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Randomized and directed bench for id_stage against a behavioural model of the decode stage.
module tb_id_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [11:0] in_instr, out_instr;
  logic [3:0]  in_pc, out_pc;
  logic [1:0]  out_rs1, out_rs2, out_rd, wb_rd;
  logic        out_rf_we, out_branch, wb_valid, br_done, flush, sb_busy;

`ifdef ID_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  int n_chk = 0;
  int n_fail = 0;

  // model state
  bit [3:0]  m_pend;
  bit        m_ov, m_br, m_we, m_isbr, m_ready;
  bit [11:0] m_instr;
  bit [3:0]  m_pc;
  bit [1:0]  m_rd;

  id_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_rf_we(out_rf_we), .out_branch(out_branch), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .br_done(br_done), .flush(flush), .sb_busy(sb_busy)
  );

  always #5 clk = ~clk;

  function automatic bit [11:0] mk(input int op, input int rd, input int rs1, input int rs2);
    return 12'((rs2 << 6) | (rs1 << 4) | (rd << 2) | op);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit busy(input int rs);
    bit [3:0] p;
    p = m_pend;
    if (BYP && wb_valid) p[wb_rd] = 1'b0;
    if (rs == 0) return 1'b0;
    return p[rs] || (m_ov && m_we && m_rd == rs);
  endfunction

  task automatic model_reset();
    m_pend = 4'd0; m_ov = 1'b0; m_br = 1'b0; m_ready = 1'b0;
  endtask

  task automatic compare();
    int rs1, rs2;
    rs1 = (int'(in_instr) >> 4) & 3;
    rs2 = (int'(in_instr) >> 6) & 3;
    m_ready = !m_br && !flush && !busy(rs1) && !busy(rs2) && (!m_ov || out_ready);
    chk("in_ready", in_ready, m_ready);
    chk("sb_busy", sb_busy, m_pend != 0);
    chk("out_valid", out_valid, m_ov);
    if (m_ov) begin
      chk("out_instr", out_instr, m_instr);
      chk("out_pc", out_pc, m_pc);
      chk("out_rs1", out_rs1, (m_instr >> 4) & 3);
      chk("out_rs2", out_rs2, (m_instr >> 6) & 3);
      chk("out_rd", out_rd, m_rd);
      chk("out_rf_we", out_rf_we, m_we);
      chk("out_branch", out_branch, m_isbr);
    end
  endtask

  task automatic update();
    bit acc, hs;
    int op, rd;
    if (rst) begin
      model_reset();
      return;
    end
    acc = in_valid && m_ready;
    hs  = m_ov && out_ready;
    if (wb_valid) m_pend[wb_rd] = 1'b0;
    if (hs && m_we) m_pend[m_rd] = 1'b1;
    m_pend[0] = 1'b0;
    op = int'(in_instr) & 3;
    rd = (int'(in_instr) >> 2) & 3;
    if (flush) m_br = 1'b0;
    else if (!m_br && acc && op == 2) m_br = 1'b1;
    else if (m_br && br_done) m_br = 1'b0;
    if (flush) m_ov = 1'b0;
    else if (acc) begin
      m_ov = 1'b1; m_instr = in_instr; m_pc = in_pc;
      m_we = (op == 0 || op == 1) && rd != 0;
      m_rd = m_we ? 2'(rd) : 2'd0;
      m_isbr = (op == 2);
    end else if (hs) m_ov = 1'b0;
  endtask

  task automatic cyc(input bit iv, input bit [11:0] ins, input bit [3:0] pc, input bit ordy,
                     input bit wbv, input bit [1:0] wbr, input bit brd, input bit fl);
    @(posedge clk);
    update();
    @(negedge clk);
    in_valid = iv; in_instr = ins; in_pc = pc; out_ready = ordy;
    wb_valid = wbv; wb_rd = wbr; br_done = brd; flush = fl;
    #1;
    compare();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = 12'd0; in_pc = 4'd0; out_ready = 1'b0;
    wb_valid = 1'b0; wb_rd = 2'd0; br_done = 1'b0; flush = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_rd", out_rd, 0);
    chk("rst_out_rf_we", out_rf_we, 0);
    chk("rst_sb_busy", sb_busy, 0);
    rst = 1'b0;

    // R rd=1 rs1=2 rs2=3, then dependent reader of r1
    cyc(1, mk(0, 1, 2, 3), 4'd1, 1, 0, 0, 0, 0); chk("d_ready0", in_ready, 1);
    cyc(0, 12'd0, 4'd0, 1, 0, 0, 0, 0);
    chk("d_ov", out_valid, 1); chk("d_rd1", out_rd, 1); chk("d_we1", out_rf_we, 1);
    cyc(1, mk(0, 2, 1, 0), 4'd2, 1, 0, 0, 0, 0); chk("d_busy1", sb_busy, 1); chk("d_stall", in_ready, 0);
    cyc(1, mk(0, 2, 1, 0), 4'd2, 1, 0, 0, 0, 0); chk("d_stall2", in_ready, 0);
    cyc(1, mk(0, 2, 1, 0), 4'd2, 1, 1, 1, 0, 0); chk("d_wb_same", in_ready, BYP);
    cyc(!BYP, mk(0, 2, 1, 0), 4'd2, 1, 0, 0, 0, 0); chk("d_wb_next", in_ready || BYP, 1);
    repeat (3) cyc(0, 12'd0, 4'd0, 1, 0, 0, 0, 0);
    cyc(0, 12'd0, 4'd0, 1, 1, 2, 0, 0);
    cyc(0, 12'd0, 4'd0, 1, 0, 0, 0, 0); chk("d_drained", sb_busy, 0);

    // I-type rd=0, then read of r0
    cyc(1, mk(1, 0, 0, 0), 4'd3, 1, 0, 0, 0, 0);
    cyc(1, mk(0, 1, 0, 0), 4'd4, 1, 0, 0, 0, 0);
    chk("d_i_we", out_rf_we, 0); chk("d_i_rd", out_rd, 0); chk("d_r0_ready", in_ready, 1);
    cyc(0, 12'd0, 4'd0, 1, 0, 0, 0, 0);
    cyc(0, 12'd0, 4'd0, 1, 1, 1, 0, 0);

    // branch stall
    cyc(1, mk(2, 3, 0, 0), 4'd5, 1, 0, 0, 0, 0); chk("d_br_acc", in_ready, 1);
    repeat (3) begin cyc(1, mk(0, 1, 0, 0), 4'd6, 1, 0, 0, 0, 0); chk("d_br_wait", in_ready, 0); end
    cyc(0, 12'd0, 4'd0, 1, 0, 0, 1, 0);
    cyc(0, 12'd0, 4'd0, 1, 0, 0, 0, 0); chk("d_br_done", in_ready, 1);

    // hold with out_ready=0, then flush
    cyc(1, mk(0, 3, 0, 0), 4'd7, 0, 0, 0, 0, 0);
    repeat (4) begin
      cyc(0, 12'd0, 4'd0, 0, 0, 0, 0, 0);
      chk("d_hold_v", out_valid, 1); chk("d_hold_rd", out_rd, 3); chk("d_hold_pc", out_pc, 7);
    end
    cyc(0, 12'd0, 4'd0, 0, 0, 0, 0, 1);
    cyc(0, 12'd0, 4'd0, 1, 0, 0, 0, 0); chk("d_flush_v", out_valid, 0); chk("d_flush_sb", sb_busy, 0);

    // writeback coincident with handoff of the same register
    cyc(1, mk(1, 2, 0, 0), 4'd8, 1, 0, 0, 0, 0);
    cyc(0, 12'd0, 4'd0, 1, 1, 2, 0, 0);
    cyc(1, mk(0, 3, 2, 0), 4'd9, 1, 0, 0, 0, 0); chk("d_setwins", sb_busy, 1); chk("d_setwins_rdy", in_ready, 0);
    cyc(0, 12'd0, 4'd0, 1, 1, 2, 0, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 3) != 0, 12'($urandom), 4'($urandom), $urandom_range(0, 3) != 0,
          $urandom_range(0, 2) == 0, 2'($urandom), $urandom_range(0, 5) == 0, $urandom_range(0, 19) == 0);
    end

    // asynchronous reset mid-operation
    cyc(1, mk(0, 1, 0, 0), 4'd1, 1, 0, 0, 0, 0);
    cyc(1, mk(0, 2, 0, 0), 4'd2, 0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("async_ov", out_valid, 0); chk("async_sb", sb_busy, 0); chk("async_rd", out_rd, 0);
    @(posedge clk); model_reset();
    @(negedge clk); rst = 1'b0; in_valid = 1'b0;
    cyc(0, 12'd0, 4'd0, 1, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
